// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction-memory read port plus decoder valid/accept port.
interface instruction_fetch_unit_if;
    // Instruction memory side
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    // Decoder side
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_accept;
    logic [63:0] pc;
    logic        branch_en;
    logic        branch_short;
    logic [25:0] branch_imm;
    // Status
    logic        fetch_fault;

    // Fetch unit view
    modport master (
        output mem_addr, mem_req, instr, instr_valid, pc, fetch_fault,
        input  mem_ready, mem_rdata, instr_accept, branch_en, branch_short, branch_imm
    );

    // Memory/decoder environment view
    modport slave (
        input  mem_addr, mem_req, instr, instr_valid, pc, fetch_fault,
        output mem_ready, mem_rdata, instr_accept, branch_en, branch_short, branch_imm
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, reads instruction memory, hands words to the
// decoder and applies PC-relative branch offsets on the accept edge.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W     = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [63:0] PC_INIT   = {RESET_PC[63:2], 2'b00};
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_fault_q, fetch_fault_d;
    logic [63:0]      pc_step;

    // PC increment: +4 sequentially, or the selected word offset scaled to bytes
    always_comb begin
        pc_step = 64'd4;
        if (bus.branch_en) begin
            if (bus.branch_short) begin
                pc_step = {{43{bus.branch_imm[18]}}, bus.branch_imm[18:0], 2'b00};
            end else begin
                pc_step = {{36{bus.branch_imm[25]}}, bus.branch_imm[25:0], 2'b00};
            end
        end
    end

    // Next-state, datapath and output decode; outputs follow the next state so
    // that they come straight from flops
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
            S_FETCH: begin
                // A response on the timeout edge still counts as a hit
                if (bus.mem_ready) begin
                    state_d = S_HOLD;
                    instr_d = bus.mem_rdata;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (bus.instr_accept) begin
                    state_d    = S_FETCH;
                    wait_cnt_d = '0;
                    pc_d       = pc_q + pc_step;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d     = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_HOLD);
        fetch_fault_d = (state_d == S_FAULT);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= PC_INIT;
            instr_q       <= '0;
            wait_cnt_q    <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign bus.mem_addr    = pc_q[31:0];
    assign bus.mem_req     = mem_req_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, decoder stall,
// branches with wrap-around, wait states, timeout fault and async reset.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    logic clock;
    logic rst_a;
    logic rst_b;

    int unsigned n_checks;
    int unsigned n_errors;

    instruction_fetch_unit_if ifa ();
    instruction_fetch_unit_if ifb ();

    // Main-path instance
    instruction_fetch_unit #(
        .RESET_PC (64'h0),
        .TIMEOUT  (255)
    ) dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (ifa.master)
    );

    // Short-timeout instance with a non-zero reset PC
    instruction_fetch_unit #(
        .RESET_PC (64'h100),
        .TIMEOUT  (4)
    ) dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (ifb.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic wait_hold_a(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (ifa.instr_valid === 1'b1) break;
            step();
        end
        check(tag, 64'(ifa.instr_valid), 64'd1);
    endtask

    // One accept edge on dut_a with the given branch fields, then release accept
    task automatic accept_a(input logic en, input logic short_sel, input logic [25:0] imm);
        ifa.branch_en    = en;
        ifa.branch_short = short_sel;
        ifa.branch_imm   = imm;
        ifa.instr_accept = 1'b1;
        step();
        ifa.instr_accept = 1'b0;
        ifa.branch_en    = 1'b0;
        ifa.branch_imm   = 26'h2AAAAAA;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.mem_ready    = 1'b1;
        ifa.mem_rdata    = 32'h8B020020;
        ifa.instr_accept = 1'b1;
        ifa.branch_en    = 1'b0;
        ifa.branch_short = 1'b0;
        ifa.branch_imm   = 26'h0;
        ifb.mem_ready    = 1'b0;
        ifb.mem_rdata    = 32'h0;
        ifb.instr_accept = 1'b0;
        ifb.branch_en    = 1'b0;
        ifb.branch_short = 1'b0;
        ifb.branch_imm   = 26'h0;
        step();
        step();

        // Reset values
        check("rst_a_pc",    ifa.pc, 64'h0);
        check("rst_a_addr",  64'(ifa.mem_addr), 64'h0);
        check("rst_a_req",   64'(ifa.mem_req), 64'd0);
        check("rst_a_instr", 64'(ifa.instr), 64'h0);
        check("rst_a_valid", 64'(ifa.instr_valid), 64'd0);
        check("rst_a_fault", 64'(ifa.fetch_fault), 64'd0);
        check("rst_b_pc",    ifb.pc, 64'h100);
        check("rst_b_addr",  64'(ifb.mem_addr), 64'h100);

        // Back-to-back fetch at peak rate
        rst_a = 1'b0;
        step();
        check("seq_req0",   64'(ifa.mem_req), 64'd1);
        check("seq_addr0",  64'(ifa.mem_addr), 64'h0);
        check("seq_valid0", 64'(ifa.instr_valid), 64'd0);
        step();
        check("seq_valid1", 64'(ifa.instr_valid), 64'd1);
        check("seq_instr1", 64'(ifa.instr), 64'h8B020020);
        check("seq_pc1",    ifa.pc, 64'h0);
        check("seq_req1",   64'(ifa.mem_req), 64'd0);
        step();
        check("seq_addr4",  64'(ifa.mem_addr), 64'h4);
        check("seq_req2",   64'(ifa.mem_req), 64'd1);
        check("seq_valid2", 64'(ifa.instr_valid), 64'd0);
        step();
        check("seq_valid3", 64'(ifa.instr_valid), 64'd1);
        check("seq_pc4",    ifa.pc, 64'h4);
        step();
        check("seq_addr8",  64'(ifa.mem_addr), 64'h8);
        check("seq_valid4", 64'(ifa.instr_valid), 64'd0);

        // Decoder stall: everything frozen, stray inputs ignored
        ifa.instr_accept = 1'b0;
        step();
        ifa.mem_rdata  = 32'hDEADBEEF;
        ifa.branch_en  = 1'b1;
        ifa.branch_imm = 26'h0000010;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(ifa.instr_valid), 64'd1);
            check("stall_req",   64'(ifa.mem_req), 64'd0);
            check("stall_instr", 64'(ifa.instr), 64'h8B020020);
            check("stall_pc",    ifa.pc, 64'h8);
            check("stall_addr",  64'(ifa.mem_addr), 64'h8);
            step();
        end
        accept_a(1'b0, 1'b0, 26'h0);
        check("stall_next_addr", 64'(ifa.mem_addr), 64'hC);
        check("stall_next_req",  64'(ifa.mem_req), 64'd1);
        wait_hold_a("hold_c");
        check("new_instr", 64'(ifa.instr), 64'hDEADBEEF);
        check("pc_c", ifa.pc, 64'hC);
        accept_a(1'b0, 1'b0, 26'h0);
        wait_hold_a("hold_10");
        check("pc_10", ifa.pc, 64'h10);

        // B-format backward branch: 0x10 - 8 = 0x08
        accept_a(1'b1, 1'b0, 26'h3FFFFFE);
        check("br_b_neg_addr", 64'(ifa.mem_addr), 64'h8);
        check("br_b_neg_req",  64'(ifa.mem_req), 64'd1);
        wait_hold_a("hold_8");
        check("pc_8", ifa.pc, 64'h8);

        // CB-format: imm[25:19] must be ignored, 0x08 + 6*4 = 0x20
        accept_a(1'b1, 1'b1, 26'h3F80006);
        check("br_cb_sel_addr", 64'(ifa.mem_addr), 64'h20);
        wait_hold_a("hold_20");

        // CB-format imm19=3: 0x20 + 12 = 0x2C
        accept_a(1'b1, 1'b1, 26'h0000003);
        check("br_cb_addr", 64'(ifa.mem_addr), 64'h2C);
        wait_hold_a("hold_2c");

        // CB-format imm19=-1: 0x2C - 4 = 0x28
        accept_a(1'b1, 1'b1, 26'h007FFFF);
        check("br_cb_neg_pc", ifa.pc, 64'h28);
        wait_hold_a("hold_28");

        // B-format -16 words from 0x28 wraps below zero
        accept_a(1'b1, 1'b0, 26'h3FFFFF0);
        check("br_wrap_pc",   ifa.pc, 64'hFFFF_FFFF_FFFF_FFE8);
        check("br_wrap_addr", 64'(ifa.mem_addr), 64'hFFFF_FFE8);
        wait_hold_a("hold_e8");

        // +5 words to the last word, then sequential step wraps to zero
        accept_a(1'b1, 1'b0, 26'h0000005);
        check("br_top_pc", ifa.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_hold_a("hold_fc");
        accept_a(1'b0, 1'b0, 26'h0);
        check("seq_wrap_pc",   ifa.pc, 64'h0);
        check("seq_wrap_addr", 64'(ifa.mem_addr), 64'h0);

        // Wait states: ready on the 4th FETCH edge, which is also the timeout edge
        rst_b = 1'b0;
        step();
        check("ws_req0",  64'(ifb.mem_req), 64'd1);
        check("ws_addr0", 64'(ifb.mem_addr), 64'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws_req",   64'(ifb.mem_req), 64'd1);
            check("ws_addr",  64'(ifb.mem_addr), 64'h100);
            check("ws_fault", 64'(ifb.fetch_fault), 64'd0);
            check("ws_valid", 64'(ifb.instr_valid), 64'd0);
        end
        ifb.mem_ready = 1'b1;
        ifb.mem_rdata = 32'hF8400123;
        step();
        check("ws_hit_valid", 64'(ifb.instr_valid), 64'd1);
        check("ws_hit_instr", 64'(ifb.instr), 64'hF8400123);
        check("ws_hit_fault", 64'(ifb.fetch_fault), 64'd0);
        check("ws_hit_pc",    ifb.pc, 64'h100);

        // Timeout: four FETCH edges with no response
        ifb.mem_ready    = 1'b0;
        ifb.instr_accept = 1'b1;
        step();
        ifb.instr_accept = 1'b0;
        check("to_addr", 64'(ifb.mem_addr), 64'h104);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_pre_fault", 64'(ifb.fetch_fault), 64'd0);
            check("to_pre_req",   64'(ifb.mem_req), 64'd1);
        end
        step();
        check("to_fault", 64'(ifb.fetch_fault), 64'd1);
        check("to_req",   64'(ifb.mem_req), 64'd0);
        ifb.mem_ready    = 1'b1;
        ifb.instr_accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_sticky_fault", 64'(ifb.fetch_fault), 64'd1);
            check("to_sticky_req",   64'(ifb.mem_req), 64'd0);
            check("to_sticky_valid", 64'(ifb.instr_valid), 64'd0);
        end
        #2 rst_b = 1'b1;
        #1;
        check("to_rst_fault", 64'(ifb.fetch_fault), 64'd0);
        check("to_rst_pc",    ifb.pc, 64'h100);

        // Async reset between edges while a fetch is outstanding
        step();
        rst_b = 1'b0;
        ifb.mem_ready    = 1'b1;
        ifb.instr_accept = 1'b1;
        ifb.mem_rdata    = 32'h12345678;
        step();
        step();
        step();
        check("ar_pre_req",  64'(ifb.mem_req), 64'd1);
        check("ar_pre_addr", 64'(ifb.mem_addr), 64'h104);
        ifb.mem_ready = 1'b0;
        #2 rst_b = 1'b1;
        #1;
        check("ar_req",   64'(ifb.mem_req), 64'd0);
        check("ar_pc",    ifb.pc, 64'h100);
        check("ar_addr",  64'(ifb.mem_addr), 64'h100);
        check("ar_valid", 64'(ifb.instr_valid), 64'd0);
        step();
        rst_b = 1'b0;
        ifb.mem_ready    = 1'b1;
        ifb.instr_accept = 1'b0;
        step();
        check("ar_refetch_req",  64'(ifb.mem_req), 64'd1);
        check("ar_refetch_addr", 64'(ifb.mem_addr), 64'h100);
        step();
        check("ar_refetch_valid", 64'(ifb.instr_valid), 64'd1);
        check("ar_refetch_pc",    ifb.pc, 64'h100);
        check("ar_refetch_instr", 64'(ifb.instr), 64'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream fetch stage for the LEGv8 datapath. Holds the program counter, issues 32-bit instruction reads to instruction memory with a request/ready handshake, and presents each fetched word and its PC to the decoder with a valid/accept handshake. PC-relative branch offsets, resolved by the decoder on the accept cycle, are applied here, so the datapath's ALU is never used for PC updates.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] are forced to 0.
- TIMEOUT, 255, number of FETCH cycles without mem_ready before a fault (minimum 1).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_addr  out  32  instruction address; always equals pc[31:0].
- mem_req  out  1  read request; high only in FETCH.
- mem_ready  in  1  memory has valid mem_rdata; sampled only while mem_req is high.
- mem_rdata  in  32  instruction word.
- instr  out  32  held instruction register.
- instr_valid  out  1  instr and pc are valid for the decoder; high only in HOLD.
- instr_accept  in  1  decoder consumes instr; sampled only while instr_valid is high.
- pc  out  64  address of the instruction being fetched or held.
- branch_en  in  1  take a branch relative to pc; sampled only on the accept edge.
- branch_short  in  1  1: use branch_imm[18:0] (CB-format); 0: use branch_imm[25:0] (B-format).
- branch_imm  in  26  signed word offset.
- fetch_fault  out  1  memory timeout; high only in FAULT.

## Operation
- States:
  - IDLE: reset state.
  - FETCH: mem_req=1.
  - HOLD: instr_valid=1.
  - FAULT: fetch_fault=1.
- Transitions:
  - IDLE→FETCH on the first rising edge after reset is released.
  - FETCH→HOLD on an edge with mem_ready=1. instr captures mem_rdata on the same edge.
  - FETCH→FAULT on an edge with mem_ready=0 and wait_cnt==TIMEOUT-1.
  - HOLD→FETCH on an edge with instr_accept=1.
  - HOLD stays in HOLD while instr_accept=0. instr and pc are held stable and no request is issued.
  - FAULT is terminal until reset.
- wait_cnt: 8+ bits wide, enough to hold TIMEOUT-1. Cleared on entry to FETCH; increments on each FETCH edge with mem_ready=0.
- If mem_ready=1 on the same edge as the timeout condition, ready wins and the state goes to HOLD.
- PC update on the accept edge:
  - branch_en=0: pc ← pc + 4.
  - branch_en=1: pc ← pc + (sext(imm) << 2). imm is the 19-bit or 26-bit field selected by branch_short, sign-extended to 64 bits.
- All PC arithmetic is modulo 2^64; wrap-around is silent. pc[1:0] is always 0.
- branch_en, branch_short and branch_imm are ignored outside the accept edge.
- mem_rdata is ignored outside a FETCH edge with mem_ready=1.
- Reset values: pc=RESET_PC (low 2 bits cleared), mem_addr=RESET_PC[31:0], mem_req=0, instr=0, instr_valid=0, fetch_fault=0, wait_cnt=0, state=IDLE.
- Reset asserted mid-fetch or mid-hold: all outputs take their reset values asynchronously. A pending memory response is dropped.

## Timing
- mem_req, instr_valid and fetch_fault are decoded from the state register only; they are glitch-free and have no combinational path from inputs.
- mem_addr is stable for the whole FETCH period, including wait states.
- Minimum latency: mem_req rises at edge N. With mem_ready=1 at edge N+1, instr_valid rises after edge N+1.
- If instr_accept=1 at edge N+2, the next mem_req rises after edge N+2.
- Peak throughput is therefore one instruction per 2 cycles.
- The first request after reset release appears one cycle after the first edge.
- Fault: with mem_ready held low, fetch_fault rises after the TIMEOUT-th FETCH edge and mem_req falls on that same edge.

## Test plan
- Reset with RESET_PC=0, mem_ready always 1, mem_rdata=32'h8B020020, instr_accept always 1. Required: instr=8B020020 with pc=0, then mem_addr=4, then 8. instr_valid pulses every 2nd cycle.
- Decoder stall: hold instr_accept=0 for 5 cycles while instr_valid=1. Required: instr, pc and mem_addr unchanged, mem_req=0 throughout. After accept, mem_addr=pc+4.
- Branches:
  - pc=0x10, accept with branch_en=1, branch_short=0, branch_imm=26'h3FFFFFE (−2). Required: next mem_addr=0x08.
  - pc=0x20, branch_short=1, imm19=3. Required: next mem_addr=0x2C.
- Wait states: mem_ready asserted on the 4th FETCH cycle. Required: mem_addr stable for all 4 cycles, instr captured correctly, no fault.
- Timeout: TIMEOUT=4, mem_ready=0 forever. Required: fetch_fault=1 and mem_req=0 after 4 FETCH edges, and both stay there. Asserting reset clears fetch_fault and pc returns to RESET_PC.
- Asynchronous reset between clock edges during FETCH, with RESET_PC=0x100. Required: mem_req=0 and pc=0x100 immediately, without waiting for a clock edge. Re-fetch from 0x100 after release.
